// File: rtl/id_operand_hazard_unit.sv
// ID-stage front end: IF->ID register with a stall-replay buffer for the synchronous instruction
// SRAM, plus rs/rt operand forwarding from NUM_FWD in-flight stages and WB with load-use interlock.

module id_fwd_sel #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2
) (
    input  logic [AW-1:0]         i_addr,
    input  logic [NUM_FWD-1:0]    i_fwd_we,
    input  logic [NUM_FWD*AW-1:0] i_fwd_waddr,
    input  logic [NUM_FWD*DW-1:0] i_fwd_wdata,
    input  logic [NUM_FWD-1:0]    i_fwd_ready,
    input  logic                  i_wb_we,
    input  logic [AW-1:0]         i_wb_waddr,
    input  logic [DW-1:0]         i_wb_wdata,
    input  logic [DW-1:0]         i_rf_rdata,
    output logic [DW-1:0]         o_data,
    output logic                  o_pend
);
    always_comb begin
        o_data = i_rf_rdata;
        o_pend = 1'b0;
        if (i_wb_we && i_wb_waddr == i_addr)
            o_data = i_wb_wdata;
        // Walk oldest to youngest so the youngest match wins, including its ready flag.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_we[i] && i_fwd_waddr[i*AW +: AW] == i_addr) begin
                o_data = i_fwd_wdata[i*DW +: DW];
                o_pend = !i_fwd_ready[i];
            end
        end
        if (i_addr == '0) begin
            o_data = '0;
            o_pend = 1'b0;
        end
    end
endmodule

module id_operand_hazard_unit #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic [STALL_W-1:0]    i_stall,
    input  logic                  i_if_ce,
    input  logic [31:0]           i_if_pc,
    input  logic [31:0]           i_inst_rdata,
    input  logic [NUM_FWD-1:0]    i_fwd_we,
    input  logic [NUM_FWD*AW-1:0] i_fwd_waddr,
    input  logic [NUM_FWD*DW-1:0] i_fwd_wdata,
    input  logic [NUM_FWD-1:0]    i_fwd_ready,
    input  logic                  i_wb_we,
    input  logic [AW-1:0]         i_wb_waddr,
    input  logic [DW-1:0]         i_wb_wdata,
    input  logic                  i_rs_used,
    input  logic                  i_rt_used,
    input  logic [DW-1:0]         i_rf_rdata1,
    input  logic [DW-1:0]         i_rf_rdata2,
    output logic                  o_id_ce,
    output logic [31:0]           o_id_pc,
    output logic [31:0]           o_id_inst,
    output logic [AW-1:0]         o_rs_addr,
    output logic [AW-1:0]         o_rt_addr,
    output logic [DW-1:0]         o_op1,
    output logic [DW-1:0]         o_op2,
    output logic                  o_stallreq,
    output logic [CNT_W-1:0]      o_stall_cnt
);
    logic             r_id_ce;
    logic [31:0]      r_id_pc;
    logic             r_hold_vld;
    logic [31:0]      r_hold_inst;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_pend1, w_pend2;
    logic             w_unused_stall;

    assign w_unused_stall = ^i_stall;

    always_ff @(posedge clk) begin
        if (rst || i_flush || (i_stall[1] && !i_stall[2])) begin
            r_id_ce    <= 1'b0;
            r_id_pc    <= '0;
            r_hold_vld <= 1'b0;
        end else if (!i_stall[1]) begin
            r_id_ce    <= i_if_ce;
            r_id_pc    <= i_if_pc;
            r_hold_vld <= 1'b0;
        end else if (!r_hold_vld) begin
            // SRAM data is only valid the cycle after fetch; capture it once for the whole stall.
            r_hold_inst <= i_inst_rdata;
            r_hold_vld  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (o_stallreq && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign o_id_ce     = r_id_ce;
    assign o_id_pc     = r_id_pc;
    assign o_id_inst   = !r_id_ce ? 32'h0 : (r_hold_vld ? r_hold_inst : i_inst_rdata);
    assign o_rs_addr   = o_id_inst[21 +: AW];
    assign o_rt_addr   = o_id_inst[16 +: AW];
    assign o_stall_cnt = r_stall_cnt;
    assign o_stallreq  = r_id_ce && ((i_rs_used && w_pend1) || (i_rt_used && w_pend2));

    id_fwd_sel #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel_rs (
        .i_addr(o_rs_addr), .i_fwd_we(i_fwd_we), .i_fwd_waddr(i_fwd_waddr),
        .i_fwd_wdata(i_fwd_wdata), .i_fwd_ready(i_fwd_ready), .i_wb_we(i_wb_we),
        .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata), .i_rf_rdata(i_rf_rdata1),
        .o_data(o_op1), .o_pend(w_pend1)
    );

    id_fwd_sel #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel_rt (
        .i_addr(o_rt_addr), .i_fwd_we(i_fwd_we), .i_fwd_waddr(i_fwd_waddr),
        .i_fwd_wdata(i_fwd_wdata), .i_fwd_ready(i_fwd_ready), .i_wb_we(i_wb_we),
        .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata), .i_rf_rdata(i_rf_rdata2),
        .o_data(o_op2), .o_pend(w_pend2)
    );
endmodule

// File: tb/tb_id_operand_hazard_unit.sv
// Directed bench: forwarding/interlock vector table plus hand-written hold, flush and counter sequences.
module tb_id_operand_hazard_unit;
    logic        clk = 1'b0;
    logic        rst, flush, if_ce, wb_we, rs_used, rt_used;
    logic [5:0]  stall;
    logic [31:0] if_pc, inst_rdata, wb_wdata, rf1, rf2;
    logic [1:0]  fwd_we, fwd_ready;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic [4:0]  wb_waddr;

    logic        id_ce, stallreq, id_ce2, stallreq2;
    logic [31:0] id_pc, id_inst, op1, op2, id_pc2, id_inst2, op1_2, op2_2;
    logic [4:0]  rs_addr, rt_addr, rs_addr2, rt_addr2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_operand_hazard_unit dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_if_ce(if_ce), .i_if_pc(if_pc),
        .i_inst_rdata(inst_rdata), .i_fwd_we(fwd_we), .i_fwd_waddr(fwd_waddr), .i_fwd_wdata(fwd_wdata),
        .i_fwd_ready(fwd_ready), .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
        .i_rs_used(rs_used), .i_rt_used(rt_used), .i_rf_rdata1(rf1), .i_rf_rdata2(rf2),
        .o_id_ce(id_ce), .o_id_pc(id_pc), .o_id_inst(id_inst), .o_rs_addr(rs_addr), .o_rt_addr(rt_addr),
        .o_op1(op1), .o_op2(op2), .o_stallreq(stallreq), .o_stall_cnt(cnt)
    );

    id_operand_hazard_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .i_flush(flush), .i_stall(stall), .i_if_ce(if_ce), .i_if_pc(if_pc),
        .i_inst_rdata(inst_rdata), .i_fwd_we(fwd_we), .i_fwd_waddr(fwd_waddr), .i_fwd_wdata(fwd_wdata),
        .i_fwd_ready(fwd_ready), .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
        .i_rs_used(rs_used), .i_rt_used(rt_used), .i_rf_rdata1(rf1), .i_rf_rdata2(rf2),
        .o_id_ce(id_ce2), .o_id_pc(id_pc2), .o_id_inst(id_inst2), .o_rs_addr(rs_addr2), .o_rt_addr(rt_addr2),
        .o_op1(op1_2), .o_op2(op2_2), .o_stallreq(stallreq2), .o_stall_cnt(cnt2)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  rdy;
        logic        wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [4:0]  rs, rt;
        logic        rsu, rtu;
        logic        chk_ops;
        logic [31:0] e1, e2;
        logic        est;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h23, rs, rt, 16'h0040};
    endfunction

    task automatic clr_fwd();
        fwd_we = 2'b00; fwd_waddr = '0; fwd_wdata = '0; fwd_ready = 2'b11;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; rs_used = 1'b0; rt_used = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; stall = '0; if_ce = 1'b0; if_pc = '0;
        clr_fwd();
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rf1 = 32'hAAAA0001; rf2 = 32'hBBBB0002;
        inst_rdata = 32'hFFFF_FFFF;
        //          we     wa0 wa1 wd0    wd1    rdy    wbwe wba wbd    rs rt rsu rtu ops e1           e2           est
        vt[0]  = '{2'b11, 8,  8,  32'h11, 32'h22, 2'b11, 1, 8,  32'h33, 8, 3, 1, 1, 1, 32'h11,       32'hBBBB0002, 0};
        vt[1]  = '{2'b10, 8,  8,  32'h11, 32'h22, 2'b11, 1, 8,  32'h33, 8, 3, 1, 1, 1, 32'h22,       32'hBBBB0002, 0};
        vt[2]  = '{2'b00, 8,  8,  32'h11, 32'h22, 2'b11, 1, 8,  32'h33, 8, 3, 1, 1, 1, 32'h33,       32'hBBBB0002, 0};
        vt[3]  = '{2'b00, 8,  8,  32'h11, 32'h22, 2'b11, 0, 8,  32'h33, 8, 3, 1, 1, 1, 32'hAAAA0001, 32'hBBBB0002, 0};
        vt[4]  = '{2'b01, 0,  0,  32'hDEAD, 0,    2'b00, 1, 0,  32'h44, 0, 0, 1, 1, 1, 32'h0,        32'h0,        0};
        vt[5]  = '{2'b01, 9,  0,  32'h99, 0,      2'b00, 0, 0,  0,      1, 9, 1, 1, 0, 32'h0,        32'h0,        1};
        vt[6]  = '{2'b01, 9,  0,  32'h99, 0,      2'b00, 0, 0,  0,      1, 9, 1, 0, 1, 32'hAAAA0001, 32'h99,       0};
        vt[7]  = '{2'b11, 9,  9,  32'h99, 32'h98, 2'b10, 0, 0,  0,      1, 9, 1, 1, 0, 32'h0,        32'h0,        1};
        vt[8]  = '{2'b11, 9,  9,  32'h99, 32'h98, 2'b01, 0, 0,  0,      1, 9, 1, 1, 1, 32'hAAAA0001, 32'h99,       0};
        vt[9]  = '{2'b10, 0,  5,  0,      32'h55, 2'b00, 0, 0,  0,      5, 2, 1, 1, 0, 32'h0,        32'h0,        1};
        vt[10] = '{2'b11, 4,  7,  32'h44, 32'h77, 2'b11, 0, 0,  0,      4, 7, 1, 1, 1, 32'h44,       32'h77,       0};
        vt[11] = '{2'b01, 4,  0,  32'h44, 0,      2'b11, 1, 12, 32'hC0, 4, 12, 1, 1, 1, 32'h44,      32'hC0,       0};

        // reset state, with SRAM data nonzero
        do_reset();
        rst = 1'b1; #1;
        chk("rst_ce", id_ce, 0); chk("rst_pc", id_pc, 0); chk("rst_inst", id_inst, 0);
        chk("rst_stallreq", stallreq, 0); chk("rst_cnt", cnt, 0);
        tick(); rst = 1'b0;

        // load a slot and apply the forwarding table
        if_ce = 1'b1; if_pc = 32'h40;
        tick();
        chk("load_ce", id_ce, 1); chk("load_pc", id_pc, 32'h40);
        for (int k = 0; k < 12; k++) begin
            fwd_we = vt[k].we; fwd_waddr = {vt[k].wa1, vt[k].wa0}; fwd_wdata = {vt[k].wd1, vt[k].wd0};
            fwd_ready = vt[k].rdy; wb_we = vt[k].wbwe; wb_waddr = vt[k].wba; wb_wdata = vt[k].wbd;
            rs_used = vt[k].rsu; rt_used = vt[k].rtu; inst_rdata = mk(vt[k].rs, vt[k].rt);
            #1;
            chk($sformatf("v%0d_rs_addr", k), rs_addr, vt[k].rs);
            chk($sformatf("v%0d_rt_addr", k), rt_addr, vt[k].rt);
            chk($sformatf("v%0d_stallreq", k), stallreq, vt[k].est);
            if (vt[k].chk_ops) begin
                chk($sformatf("v%0d_op1", k), op1, vt[k].e1);
                chk($sformatf("v%0d_op2", k), op2, vt[k].e2);
            end
        end

        // load-use on r9 via rt: two interlock cycles, then ready releases it
        do_reset();
        if_ce = 1'b1; if_pc = 32'h100; inst_rdata = mk(1, 9);
        fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd9}; fwd_wdata = {32'h0, 32'h9999}; fwd_ready = 2'b00;
        rt_used = 1'b1;
        #1; chk("lu_pre_stallreq", stallreq, 0);
        tick(); chk("lu_c1_stallreq", stallreq, 1); chk("lu_c1_cnt", cnt, 0);
        tick(); chk("lu_c2_stallreq", stallreq, 1); chk("lu_c2_cnt", cnt, 1);
        tick(); chk("lu_c3_cnt", cnt, 2);
        fwd_ready = 2'b01; #1;
        chk("lu_rel_stallreq", stallreq, 0); chk("lu_rel_op2", op2, 32'h9999);
        tick(); chk("lu_hold_cnt", cnt, 2);

        // five interlock cycles: 2-bit counter saturates; flush keeps the count
        fwd_ready = 2'b00;
        repeat (5) tick();
        chk("sat_cnt16", cnt, 7); chk("sat_cnt2", cnt2, 3);
        fwd_ready = 2'b01; flush = 1'b1;
        tick(); flush = 1'b0;
        chk("flush_ce", id_ce, 0); chk("flush_cnt16", cnt, 7); chk("flush_cnt2", cnt2, 3);

        // stall hold: first-cycle SRAM data replayed across a 3-cycle stall
        do_reset();
        if_ce = 1'b1; if_pc = 32'h200; inst_rdata = 32'hA000_000A;
        tick(); chk("h_load_inst", id_inst, 32'hA000_000A);
        stall = 6'b000110; if_pc = 32'h204;
        tick(); inst_rdata = 32'hB000_000B; #1;
        chk("h1_inst", id_inst, 32'hA000_000A);
        tick(); inst_rdata = 32'hC000_000C; #1;
        chk("h2_inst", id_inst, 32'hA000_000A); chk("h2_pc", id_pc, 32'h200); chk("h2_ce", id_ce, 1);
        tick(); chk("h3_inst", id_inst, 32'hA000_000A);
        stall = '0; inst_rdata = 32'hD000_000D;
        tick(); chk("rel_inst", id_inst, 32'hD000_000D); chk("rel_pc", id_pc, 32'h204);

        // bubble on ID input stall alone
        stall = 6'b000010;
        tick(); chk("bub_ce", id_ce, 0); chk("bub_pc", id_pc, 0); chk("bub_inst", id_inst, 0);

        // flush mid-hold discards the held word
        stall = '0; if_pc = 32'h300; inst_rdata = 32'h1111_1111;
        tick();
        stall = 6'b000110;
        tick(); inst_rdata = 32'h2222_2222; #1;
        chk("fh_hold_inst", id_inst, 32'h1111_1111);
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("fh_ce", id_ce, 0); chk("fh_inst", id_inst, 0);
        stall = '0; if_pc = 32'h304; inst_rdata = 32'hEEEE_EEEE;
        tick(); chk("fh_after_inst", id_inst, 32'hEEEE_EEEE); chk("fh_after_pc", id_pc, 32'h304);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
